// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants, format codes and the per-entry decode kind used by the
// pipelined immediate generator.
package imm_gen_pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FMT_W   = 3;
    localparam int unsigned CNT_W   = 2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [FMT_W-1:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_J   = 3'd3,
        FMT_U   = 3'd4,
        FMT_R   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_kind_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and decode-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [XLEN-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_imm;
    logic [FMT_W-1:0]   out_fmt;
    logic               out_illegal;
    logic [XLEN-1:0]    out_target;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational decode of a raw instruction word into its sign-extended immediate,
// format code and illegal flag.
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm_c,
    output imm_fmt_e           fmt_c,
    output logic               illegal_c
);

    // Every recognised opcode ends in 2'b11, so compressed encodings fall to the default.
    always_comb begin
        fmt_c = FMT_ILL;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_c = FMT_I;
            OPC_OP_IMM_32: fmt_c = (XLEN == 64) ? FMT_I : FMT_ILL;
            OPC_STORE:     fmt_c = FMT_S;
            OPC_BRANCH:    fmt_c = FMT_B;
            OPC_JAL:       fmt_c = FMT_J;
            OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
            OPC_OP:        fmt_c = FMT_R;
            OPC_OP_32:     fmt_c = (XLEN == 64) ? FMT_R : FMT_ILL;
            default:       fmt_c = FMT_ILL;
        endcase
    end

    // Signed size casts sign-extend each gathered field from instr[31].
    always_comb begin
        imm_c = '0;
        case (fmt_c)
            FMT_I: imm_c = XLEN'($signed(instr[31:20]));
            FMT_S: imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_J: imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            FMT_U: imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            default: imm_c = '0;
        endcase
    end

    assign illegal_c = (fmt_c == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode plus pc+imm ahead of a 2-entry FIFO built as
// head/tail slots, so every out_* bit comes straight from a flop.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input logic          clk,
    input logic          reset,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] ext_imm;
    imm_fmt_e        ext_fmt;
    logic            ext_illegal;
    logic [XLEN-1:0] new_tgt;
    imm_kind_t       new_kind;

    logic [XLEN-1:0]  head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
    logic [XLEN-1:0]  head_tgt_q, head_tgt_d, tail_tgt_q, tail_tgt_d;
    imm_kind_t        head_kind_q, head_kind_d, tail_kind_q, tail_kind_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr     (bus.in_instr),
        .imm_c     (ext_imm),
        .fmt_c     (ext_fmt),
        .illegal_c (ext_illegal)
    );

    assign new_tgt  = bus.in_pc + ext_imm;
    assign new_kind = '{fmt: ext_fmt, illegal: ext_illegal};
    assign push     = bus.in_valid & in_ready_q;
    assign pop      = out_valid_q & bus.out_ready;

    always_comb begin
        head_imm_d  = head_imm_q;
        head_tgt_d  = head_tgt_q;
        head_kind_d = head_kind_q;
        tail_imm_d  = tail_imm_q;
        tail_tgt_d  = tail_tgt_q;
        tail_kind_d = tail_kind_q;
        count_d     = count_q;

        if (reset) begin
            head_imm_d  = '0;
            head_tgt_d  = '0;
            head_kind_d = '{fmt: FMT_I, illegal: 1'b0};
            tail_imm_d  = '0;
            tail_tgt_d  = '0;
            tail_kind_d = '{fmt: FMT_I, illegal: 1'b0};
            count_d     = '0;
        end else if (bus.flush) begin
            count_d = '0;
        end else begin
            case (count_q)
                CNT_W'(0): begin
                    if (push) begin
                        head_imm_d  = ext_imm;
                        head_tgt_d  = new_tgt;
                        head_kind_d = new_kind;
                        count_d     = CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (push && pop) begin
                        head_imm_d  = ext_imm;
                        head_tgt_d  = new_tgt;
                        head_kind_d = new_kind;
                    end else if (push) begin
                        tail_imm_d  = ext_imm;
                        tail_tgt_d  = new_tgt;
                        tail_kind_d = new_kind;
                        count_d     = CNT_FULL;
                    end else if (pop) begin
                        count_d = CNT_W'(0);
                    end
                end
                CNT_FULL: begin
                    // in_ready is low when full, so only a pop can happen here.
                    if (pop) begin
                        head_imm_d  = tail_imm_q;
                        head_tgt_d  = tail_tgt_q;
                        head_kind_d = tail_kind_q;
                        count_d     = CNT_W'(1);
                    end
                end
                default: count_d = '0;
            endcase
        end

        out_valid_d = (count_d != '0);
        in_ready_d  = !reset && (count_d != CNT_FULL);
    end

    always_ff @(posedge clk) begin
        head_imm_q  <= head_imm_d;
        head_tgt_q  <= head_tgt_d;
        head_kind_q <= head_kind_d;
        tail_imm_q  <= tail_imm_d;
        tail_tgt_q  <= tail_tgt_d;
        tail_kind_q <= tail_kind_d;
        count_q     <= count_d;
        out_valid_q <= out_valid_d;
        in_ready_q  <= in_ready_d;
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = head_imm_q;
    assign bus.out_target  = head_tgt_q;
    assign bus.out_fmt     = head_kind_q.fmt;
    assign bus.out_illegal = head_kind_q.illegal;

endmodule
